// File: rtl/csi2_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | csi2_pkg : shared CSI-2 data-type codes and sequencer state enum|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package csi2_pkg;

   localparam logic [5:0] DT_FS = 6'h00;
   localparam logic [5:0] DT_FE = 6'h01;
   localparam logic [5:0] DT_LS = 6'h02;
   localparam logic [5:0] DT_LE = 6'h03;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_FS  = 2'd1,
      IN_FRAME = 2'd2,
      DRAIN    = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/csi2_watchdog.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | csi2_watchdog : idle-cycle counter, o_expired is a comb. strobe |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module csi2_watchdog #(
   parameter int                   TIMEOUT_W = 24,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 24'd10_000_000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic i_enable,
   input  logic i_clear,
   output logic o_expired
);

   generate
      if (TIMEOUT == '0) begin : g_disabled
         assign o_expired = 1'b0;
      end else begin : g_enabled
         localparam logic [TIMEOUT_W-1:0] c_last = TIMEOUT - 1'b1;

         logic [TIMEOUT_W-1:0] r_cnt;
         logic                 w_hit;

         // Expiry is flagged while the count sits at TIMEOUT-1 so the
         // registered consumer reacts exactly TIMEOUT idle cycles in.
         assign w_hit     = i_enable && !i_clear && (r_cnt == c_last);
         assign o_expired = w_hit;

         always_ff @(posedge clk_i) begin
            if (!rst_i) begin
               r_cnt <= '0;
            end else if (!i_enable || i_clear || w_hit) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/csi2_stream_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | csi2_stream_ctrl : CSI-2 RX frame/line sequencer with watchdog. |
// | Optional: CSI2_LINE_LEN_CHECK_EN enables word-count consistency.|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module csi2_stream_ctrl
   import csi2_pkg::*;
#(
   parameter logic [1:0]           VC         = 2'd0,
   parameter int                   LINE_CNT_W = 16,
   parameter int                   TIMEOUT_W  = 24,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT    = 24'd10_000_000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic                  short_pkt_valid_i,
   input  logic [1:0]            short_pkt_v_channel_i,
   input  logic [5:0]            short_pkt_data_type_i,
   input  logic [15:0]           short_pkt_data_field_i,
   input  logic                  long_pkt_header_valid_i,
   input  logic [1:0]            long_pkt_v_channel_i,
   input  logic [15:0]           long_pkt_word_cnt_i,
   input  logic                  long_pkt_eop_i,
   input  logic                  crc_failed_i,
   input  logic                  header_error_i,
   output logic                  phy_enable_o,
   output logic                  frame_active_o,
   output logic [15:0]           frame_num_o,
   output logic [LINE_CNT_W-1:0] line_cnt_o,
   output logic                  frame_done_o,
   output logic                  frame_err_o,
   output logic                  timeout_o,
   output logic [15:0]           crc_err_cnt_o,
   output logic                  line_len_err_o,
   output logic [1:0]            state_o
);

   state_t                r_state;
   logic                  r_phy_enable;
   logic                  r_frame_active;
   logic [15:0]           r_frame_num;
   logic [LINE_CNT_W-1:0] r_line_cnt;
   logic                  r_frame_done;
   logic                  r_frame_err;
   logic                  r_timeout;
   logic [15:0]           r_crc_err_cnt;
   logic                  r_err_flag;
   logic                  r_line_open;

   logic w_fs, w_fe, w_hdr, w_in_frame, w_err_now, w_len_mismatch;
   logic w_wd_clear, w_wd_hit;

   assign w_fs       = short_pkt_valid_i && (short_pkt_v_channel_i == VC)
                       && (short_pkt_data_type_i == DT_FS);
   assign w_fe       = short_pkt_valid_i && (short_pkt_v_channel_i == VC)
                       && (short_pkt_data_type_i == DT_FE);
   assign w_hdr      = long_pkt_header_valid_i && (long_pkt_v_channel_i == VC);
   assign w_in_frame = (r_state == IN_FRAME) || (r_state == DRAIN);
   assign w_err_now  = r_err_flag || crc_failed_i || header_error_i || w_len_mismatch;

   // Every other state change coincides with a packet strobe, a timeout
   // restart or entry to IDLE, so only stop needs to clear explicitly.
   assign w_wd_clear = short_pkt_valid_i || long_pkt_header_valid_i || long_pkt_eop_i
                       || (stop_i && ((r_state == WAIT_FS) || (r_state == IN_FRAME)));

   csi2_watchdog #(
      .TIMEOUT_W (TIMEOUT_W),
      .TIMEOUT   (TIMEOUT)
   ) u_watchdog (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .i_enable  (r_state != IDLE),
      .i_clear   (w_wd_clear),
      .o_expired (w_wd_hit)
   );

`ifdef CSI2_LINE_LEN_CHECK_EN
   logic [15:0] r_first_wc;
   logic        r_first_wc_valid;
   logic        r_line_len_err;

   assign w_len_mismatch = w_in_frame && w_hdr && r_first_wc_valid
                           && (long_pkt_word_cnt_i != r_first_wc);
   assign line_len_err_o = r_line_len_err;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_first_wc       <= '0;
         r_first_wc_valid <= 1'b0;
         r_line_len_err   <= 1'b0;
      end else begin
         r_line_len_err <= w_len_mismatch;
         if (w_fs && (w_in_frame || ((r_state == WAIT_FS) && !stop_i))) begin
            r_first_wc_valid <= 1'b0;
         end else if (w_in_frame && w_hdr && !r_first_wc_valid) begin
            r_first_wc       <= long_pkt_word_cnt_i;
            r_first_wc_valid <= 1'b1;
         end
      end
   end
`else
   logic w_unused_word_cnt;

   assign w_unused_word_cnt = ^long_pkt_word_cnt_i;
   assign w_len_mismatch    = 1'b0;
   assign line_len_err_o    = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state        <= IDLE;
         r_phy_enable   <= 1'b0;
         r_frame_active <= 1'b0;
         r_frame_num    <= '0;
         r_line_cnt     <= '0;
         r_frame_done   <= 1'b0;
         r_frame_err    <= 1'b0;
         r_timeout      <= 1'b0;
         r_crc_err_cnt  <= '0;
         r_err_flag     <= 1'b0;
         r_line_open    <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         r_frame_err  <= 1'b0;
         r_timeout    <= w_wd_hit;

         if (crc_failed_i && (r_state != IDLE) && (r_crc_err_cnt != 16'hFFFF)) begin
            r_crc_err_cnt <= r_crc_err_cnt + 1'b1;
         end

         case (r_state)
            IDLE: begin
               // Also gives the one-cycle enable tail after a drained frame.
               r_phy_enable <= start_i && !stop_i;
               if (start_i && !stop_i) begin
                  r_state <= WAIT_FS;
               end
            end

            WAIT_FS: begin
               if (stop_i) begin
                  r_state      <= IDLE;
                  r_phy_enable <= 1'b0;
               end else if (w_fs) begin
                  r_state        <= IN_FRAME;
                  r_frame_active <= 1'b1;
                  r_frame_num    <= short_pkt_data_field_i;
                  r_line_cnt     <= '0;
                  r_err_flag     <= 1'b0;
                  r_line_open    <= 1'b0;
               end
            end

            IN_FRAME, DRAIN: begin
               if (long_pkt_eop_i && r_line_open && (r_line_cnt != '1)) begin
                  r_line_cnt <= r_line_cnt + 1'b1;
               end
               if (w_hdr) begin
                  r_line_open <= 1'b1;
               end else if (long_pkt_eop_i) begin
                  r_line_open <= 1'b0;
               end
               r_err_flag <= w_err_now;

               if (w_wd_hit || w_fe) begin
                  r_frame_done   <= 1'b1;
                  r_frame_err    <= w_wd_hit ? 1'b1 : w_err_now;
                  r_frame_active <= 1'b0;
                  r_state        <= (r_state == DRAIN) ? IDLE : WAIT_FS;
               end else begin
                  // A second FS aborts the open frame and starts a new one.
                  if (w_fs) begin
                     r_frame_done <= 1'b1;
                     r_frame_err  <= 1'b1;
                     r_frame_num  <= short_pkt_data_field_i;
                     r_line_cnt   <= '0;
                     r_err_flag   <= 1'b0;
                     r_line_open  <= 1'b0;
                  end
                  if (stop_i && (r_state == IN_FRAME)) begin
                     r_state <= DRAIN;
                  end
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign phy_enable_o   = r_phy_enable;
   assign frame_active_o = r_frame_active;
   assign frame_num_o    = r_frame_num;
   assign line_cnt_o     = r_line_cnt;
   assign frame_done_o   = r_frame_done;
   assign frame_err_o    = r_frame_err;
   assign timeout_o      = r_timeout;
   assign crc_err_cnt_o  = r_crc_err_cnt;
   assign state_o        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_csi2_stream_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_csi2_stream_ctrl : directed + randomized frame bench         |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_csi2_stream_ctrl;

   localparam logic [5:0] c_dt_fs = 6'h00;
   localparam logic [5:0] c_dt_fe = 6'h01;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i, stop_i;
   logic        short_pkt_valid_i;
   logic [1:0]  short_pkt_v_channel_i;
   logic [5:0]  short_pkt_data_type_i;
   logic [15:0] short_pkt_data_field_i;
   logic        long_pkt_header_valid_i;
   logic [1:0]  long_pkt_v_channel_i;
   logic [15:0] long_pkt_word_cnt_i;
   logic        long_pkt_eop_i;
   logic        crc_failed_i, header_error_i;
   logic        phy_enable_o, frame_active_o, frame_done_o, frame_err_o, timeout_o;
   logic [15:0] frame_num_o, line_cnt_o, crc_err_cnt_o;
   logic        line_len_err_o;
   logic [1:0]  state_o;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_crc  = 0;
   bit len_chk_en;

   always #5 clk = ~clk;

   csi2_stream_ctrl #(
      .VC         (2'd0),
      .LINE_CNT_W (16),
      .TIMEOUT_W  (24),
      .TIMEOUT    (24'd100)
   ) dut (
      .clk_i                   (clk),
      .rst_i                   (rst_i),
      .start_i                 (start_i),
      .stop_i                  (stop_i),
      .short_pkt_valid_i       (short_pkt_valid_i),
      .short_pkt_v_channel_i   (short_pkt_v_channel_i),
      .short_pkt_data_type_i   (short_pkt_data_type_i),
      .short_pkt_data_field_i  (short_pkt_data_field_i),
      .long_pkt_header_valid_i (long_pkt_header_valid_i),
      .long_pkt_v_channel_i    (long_pkt_v_channel_i),
      .long_pkt_word_cnt_i     (long_pkt_word_cnt_i),
      .long_pkt_eop_i          (long_pkt_eop_i),
      .crc_failed_i            (crc_failed_i),
      .header_error_i          (header_error_i),
      .phy_enable_o            (phy_enable_o),
      .frame_active_o          (frame_active_o),
      .frame_num_o             (frame_num_o),
      .line_cnt_o              (line_cnt_o),
      .frame_done_o            (frame_done_o),
      .frame_err_o             (frame_err_o),
      .timeout_o               (timeout_o),
      .crc_err_cnt_o           (crc_err_cnt_o),
      .line_len_err_o          (line_len_err_o),
      .state_o                 (state_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_short(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] df);
      short_pkt_valid_i      = 1'b1;
      short_pkt_v_channel_i  = vc;
      short_pkt_data_type_i  = dt;
      short_pkt_data_field_i = df;
      tick();
      short_pkt_valid_i = 1'b0;
   endtask

   task automatic send_hdr(input logic [1:0] vc, input logic [15:0] wc);
      long_pkt_header_valid_i = 1'b1;
      long_pkt_v_channel_i    = vc;
      long_pkt_word_cnt_i     = wc;
      tick();
      long_pkt_header_valid_i = 1'b0;
   endtask

   task automatic send_eop();
      gap($urandom_range(0, 2));
      long_pkt_eop_i = 1'b1;
      tick();
      long_pkt_eop_i = 1'b0;
   endtask

   task automatic pulse_err(input logic crc, input logic hdr);
      crc_failed_i   = crc;
      header_error_i = hdr;
      tick();
      crc_failed_i   = 1'b0;
      header_error_i = 1'b0;
   endtask

   initial begin
      logic [15:0] fn;
      int          n_ev, kind, lines;
      bit          open, err;

`ifdef CSI2_LINE_LEN_CHECK_EN
      len_chk_en = 1'b1;
`else
      len_chk_en = 1'b0;
`endif
      rst_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
      short_pkt_valid_i = 1'b0; short_pkt_v_channel_i = '0;
      short_pkt_data_type_i = '0; short_pkt_data_field_i = '0;
      long_pkt_header_valid_i = 1'b0; long_pkt_v_channel_i = '0;
      long_pkt_word_cnt_i = '0; long_pkt_eop_i = 1'b0;
      crc_failed_i = 1'b0; header_error_i = 1'b0;
      gap(3);

      chk("rst_state", state_o, 0);
      chk("rst_phy", phy_enable_o, 0);
      chk("rst_outputs", {frame_active_o, frame_done_o, frame_err_o, timeout_o, line_len_err_o}, 0);
      chk("rst_counters", {frame_num_o, line_cnt_o}, 0);
      chk("rst_crc_cnt", crc_err_cnt_o, 0);
      rst_i = 1'b1;
      tick();

      // start and stop together: stop wins
      start_i = 1'b1; stop_i = 1'b1; tick(); start_i = 1'b0; stop_i = 1'b0;
      chk("start_stop_state", state_o, 0);
      chk("start_stop_phy", phy_enable_o, 0);

      start_i = 1'b1; tick(); start_i = 1'b0;
      chk("start_state", state_o, 1);
      chk("start_phy", phy_enable_o, 1);

      // basic frame: FS(5), three lines, FE
      send_short(2'd0, c_dt_fs, 16'd5);
      chk("fs5_state", state_o, 2);
      chk("fs5_active", frame_active_o, 1);
      chk("fs5_num", frame_num_o, 5);
      for (int i = 0; i < 3; i++) begin
         send_hdr(2'd0, 16'd1280);
         send_eop();
      end
      chk("fs5_lines", line_cnt_o, 3);
      send_short(2'd0, c_dt_fe, 16'd5);
      chk("fe5_done", frame_done_o, 1);
      chk("fe5_err", frame_err_o, 0);
      chk("fe5_state", state_o, 1);
      chk("fe5_active", frame_active_o, 0);
      chk("fe5_lines_hold", line_cnt_o, 3);
      tick();
      chk("fe5_done_pulse", frame_done_o, 0);
      chk("fe5_lines_stable", line_cnt_o, 3);

      // CRC failure coinciding with FE
      send_short(2'd0, c_dt_fs, 16'd6);
      send_hdr(2'd0, 16'd1280);
      send_eop();
      crc_failed_i = 1'b1;
      send_short(2'd0, c_dt_fe, 16'd6);
      crc_failed_i = 1'b0;
      exp_crc++;
      chk("fe_crc_done", frame_done_o, 1);
      chk("fe_crc_err", frame_err_o, 1);
      chk("fe_crc_cnt", crc_err_cnt_o, exp_crc);

      // foreign-VC FS ignored while waiting
      send_short(2'd1, c_dt_fs, 16'd77);
      chk("vc1_fs_state", state_o, 1);
      chk("vc1_fs_active", frame_active_o, 0);

      // FS inside a frame, reserved DT and foreign FE ignored
      send_short(2'd0, c_dt_fs, 16'd1);
      send_short(2'd0, 6'h05, 16'd99);
      chk("dt05_done", frame_done_o, 0);
      chk("dt05_num", frame_num_o, 1);
      send_hdr(2'd0, 16'd1280);
      send_eop();
      send_short(2'd0, c_dt_fs, 16'd2);
      chk("refs_done", frame_done_o, 1);
      chk("refs_err", frame_err_o, 1);
      chk("refs_num", frame_num_o, 2);
      chk("refs_active", frame_active_o, 1);
      chk("refs_lines", line_cnt_o, 0);
      send_short(2'd1, c_dt_fe, 16'd2);
      chk("vc1_fe_done", frame_done_o, 0);
      chk("vc1_fe_active", frame_active_o, 1);
      chk("vc1_fe_state", state_o, 2);
      send_short(2'd0, c_dt_fe, 16'd2);
      chk("refs_fe_done", frame_done_o, 1);
      chk("refs_fe_err", frame_err_o, 0);

      // randomized frames against a transaction-level model
      for (int f = 0; f < 6; f++) begin
         fn    = 16'($urandom_range(0, 65535));
         n_ev  = $urandom_range(2, 8);
         lines = 0;
         open  = 1'b0;
         err   = 1'b0;
         gap($urandom_range(1, 3));
         send_short(2'd0, c_dt_fs, fn);
         chk("rnd_fs_num", frame_num_o, fn);
         chk("rnd_fs_lines", line_cnt_o, 0);
         for (int e = 0; e < n_ev; e++) begin
            kind = $urandom_range(0, 4);
            case (kind)
               0: begin
                  send_hdr(2'd0, 16'd1280);
                  send_eop();
                  lines++;
                  open = 1'b0;
               end
               1: begin
                  send_hdr(2'd0, 16'd1280);
                  open = 1'b1;
               end
               2: begin
                  send_hdr(2'($urandom_range(1, 3)), 16'd640);
                  send_eop();
                  if (open) lines++;
                  open = 1'b0;
               end
               3: begin
                  pulse_err(1'b1, 1'b0);
                  exp_crc++;
                  err = 1'b1;
               end
               default: begin
                  pulse_err(1'b0, 1'b1);
                  err = 1'b1;
               end
            endcase
         end
         send_short(2'd0, c_dt_fe, fn);
         chk("rnd_fe_done", frame_done_o, 1);
         chk("rnd_fe_err", frame_err_o, err);
         chk("rnd_fe_lines", line_cnt_o, lines);
         chk("rnd_crc_cnt", crc_err_cnt_o, exp_crc);
      end

      // graceful stop: DRAIN until FE, then IDLE, enable drops a cycle later
      send_short(2'd0, c_dt_fs, 16'd9);
      stop_i = 1'b1; tick(); stop_i = 1'b0;
      chk("drain_state", state_o, 3);
      chk("drain_phy", phy_enable_o, 1);
      for (int i = 0; i < 2; i++) begin
         send_hdr(2'd0, 16'd1280);
         send_eop();
      end
      chk("drain_state_hold", state_o, 3);
      send_short(2'd0, c_dt_fe, 16'd9);
      chk("drain_done", frame_done_o, 1);
      chk("drain_lines", line_cnt_o, 2);
      chk("drain_idle", state_o, 0);
      chk("drain_phy_tail", phy_enable_o, 1);
      tick();
      chk("drain_phy_off", phy_enable_o, 0);

      // watchdog: FS then silence for 100 cycles
      start_i = 1'b1; tick(); start_i = 1'b0;
      send_short(2'd0, c_dt_fs, 16'd3);
      gap(99);
      chk("wd_early", timeout_o, 0);
      chk("wd_early_state", state_o, 2);
      tick();
      chk("wd_timeout", timeout_o, 1);
      chk("wd_done", frame_done_o, 1);
      chk("wd_err", frame_err_o, 1);
      chk("wd_state", state_o, 1);
      chk("wd_active", frame_active_o, 0);
      tick();
      chk("wd_pulse", timeout_o, 0);
      gap(99);
      chk("wd_restart", timeout_o, 1);
      chk("wd_restart_nodone", frame_done_o, 0);
      chk("wd_restart_state", state_o, 1);

      // word-count consistency: 1280, 1280, 1000
      send_short(2'd0, c_dt_fs, 16'd7);
      send_hdr(2'd0, 16'd1280); send_eop();
      send_hdr(2'd0, 16'd1280);
      chk("len_same", line_len_err_o, 0);
      send_eop();
      send_hdr(2'd0, 16'd1000);
      chk("len_diff", line_len_err_o, len_chk_en);
      send_eop();
      chk("len_pulse", line_len_err_o, 0);
      send_short(2'd0, c_dt_fe, 16'd7);
      chk("len_fe_err", frame_err_o, len_chk_en);
      chk("len_lines", line_cnt_o, 3);
      chk("final_crc_cnt", crc_err_cnt_o, exp_crc);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
